// File: rtl/bp_me_pkg.sv
// Shared types for the memory-engine cfg/io path.
// The processor-configuration values (paddr, block width, LCE id width,
// associativity) are fixed here and stand in for the processor config.
// Contents: command enum, message structs, responder FSM state enum,
// and a helper that decodes which commands touch the cfg register port.
package bp_me_pkg;

  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 512;
  localparam int lce_id_width_p    = 2;
  localparam int lce_assoc_p       = 8;
  localparam int lce_way_width_lp  = $clog2(lce_assoc_p);

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_wb    = 4'd4,
    e_cce_mem_pre   = 4'd5
  } bp_cce_mem_cmd_type_e;

  typedef struct packed {
    logic [lce_way_width_lp-1:0] way_id;
    logic [lce_id_width_p-1:0]   lce_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_payload_s       payload;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    bp_cce_mem_cmd_type_e      msg_type;
  } bp_cce_mem_header_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_cce_mem_header_s           header;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [1:0] {
    eReset = 2'd0,
    eRun   = 2'd1,
    eFull  = 2'd2
  } bp_me_cfg_io_state_e;

  // Only uncached reads/writes map onto the flat cfg register port.
  function automatic logic is_cfg_cmd(bp_cce_mem_cmd_type_e t);
    return (t == e_cce_mem_uc_rd) || (t == e_cce_mem_uc_wr);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular response buffer, one write port and one read port.
// Ports: clk_i, reset_n_i (async, active low, discards contents),
//        v_i/data_i   enqueue (caller guarantees a free slot),
//        v_o/data_o   head entry, valid while not empty,
//        yumi_i       dequeue the head; ignored while empty.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                deq;

  assign v_o    = (cnt_r != '0);
  assign deq    = yumi_i & v_o;
  assign data_o = mem_r[rptr_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (v_i) wptr_r <= (wptr_r == last_lp) ? '0 : wptr_r + ptr_w_lp'(1);
      if (deq) rptr_r <= (rptr_r == last_lp) ? '0 : rptr_r + ptr_w_lp'(1);
      case ({v_i, deq})
        2'b10:   cnt_r <= cnt_r + cnt_w_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_w_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage needs no reset; validity is carried by cnt_r.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_me_cfg_io_responder.sv
// Responder end of the CCE cfg/io command channel. Each accepted io command
// becomes one uncached cfg register access plus one buffered io response.
// Ports: clk_i, reset_n_i (async, active low)
//        io_cmd_i/io_cmd_v_i/io_cmd_ready_o     command in, valid/ready
//        io_resp_o/io_resp_v_o/io_resp_yumi_i   response out, valid/yumi
//        cfg_w_v_o/cfg_r_v_o/cfg_addr_o/cfg_data_o/cfg_data_i  cfg port
//        err_o                                  sticky unsupported-command flag
//
// state  | meaning
// eReset | leaving reset, not accepting commands
// eRun   | accepting; buffer has a free slot
// eFull  | buffer holds resp_els_p responses, commands stalled
module bp_me_cfg_io_responder
  import bp_me_pkg::*;
#(
  parameter int resp_els_p       = 2,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,
  output logic                            cfg_w_v_o,
  output logic                            cfg_r_v_o,
  output logic [cfg_addr_width_p-1:0]     cfg_addr_o,
  output logic [cfg_data_width_p-1:0]     cfg_data_o,
  input  logic [cfg_data_width_p-1:0]     cfg_data_i,
  output logic                            err_o
);

  localparam int count_w_lp = $clog2(resp_els_p + 1);
  localparam logic [count_w_lp-1:0] els_lp = count_w_lp'(resp_els_p);

  bp_me_cfg_io_state_e   state_r;
  logic [count_w_lp-1:0] count_r, count_n;
  logic                  ready_r, err_r;
  logic                  accept, deq, is_wr, is_rd;
  bp_cce_mem_msg_s       cmd, resp_in;

  assign cmd    = io_cmd_i;
  assign accept = io_cmd_v_i & ready_r;
  assign deq    = io_resp_v_o & io_resp_yumi_i;
  assign is_wr  = (cmd.header.msg_type == e_cce_mem_uc_wr);
  assign is_rd  = (cmd.header.msg_type == e_cce_mem_uc_rd);

  assign cfg_w_v_o      = accept & is_wr;
  assign cfg_r_v_o      = accept & is_rd;
  assign cfg_addr_o     = cmd.header.addr[cfg_addr_width_p-1:0];
  assign cfg_data_o     = cmd.data[cfg_data_width_p-1:0];
  assign io_cmd_ready_o = ready_r;
  assign err_o          = err_r;

  // Only the low cfg_data_width_p data bits of a command are consumed.
  if (cfg_data_width_p < cce_block_width_p) begin : g_unused
    logic unused_data;
    assign unused_data = ^cmd.data[cce_block_width_p-1:cfg_data_width_p];
  end

  always_comb begin
    resp_in        = '0;
    resp_in.header = cmd.header;
    if (is_rd) resp_in.data[cfg_data_width_p-1:0] = cfg_data_i;
  end

  always_comb begin
    count_n = count_r;
    if (accept && !deq)      count_n = count_r + count_w_lp'(1);
    else if (!accept && deq) count_n = count_r - count_w_lp'(1);
  end

  // ready looks at the next count so a dequeue from full reopens the port on
  // the following cycle; the eReset guard holds it low one extra cycle after
  // reset so the first accept comes two edges after release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eReset;
      count_r <= '0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_n;
      ready_r <= (state_r != eReset) && (count_n < els_lp);
      if (accept && !is_cfg_cmd(cmd.header.msg_type)) err_r <= 1'b1;
      case (state_r)
        eReset:  state_r <= eRun;
        eRun:    if (count_n == els_lp) state_r <= eFull;
        eFull:   if (count_n != els_lp) state_r <= eRun;
        default: state_r <= eReset;
      endcase
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p(cce_mem_msg_width_lp),
    .els_p  (resp_els_p)
  ) resp_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (accept),
    .data_i   (resp_in),
    .v_o      (io_resp_v_o),
    .data_o   (io_resp_o),
    .yumi_i   (deq)
  );

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    io_resp_yumi_i |-> io_resp_v_o);

  strobes_exclusive: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(cfg_w_v_o && cfg_r_v_o));

endmodule

// File: tb/tb_bp_me_cfg_io_responder.sv
module tb_bp_me_cfg_io_responder;
  import bp_me_pkg::*;

  logic                            clk_i = 1'b0;
  logic                            reset_n_i = 1'b1;
  logic [cce_mem_msg_width_lp-1:0] io_cmd_i;
  logic                            io_cmd_v_i;
  logic                            io_cmd_ready_o;
  logic [cce_mem_msg_width_lp-1:0] io_resp_o;
  logic                            io_resp_v_o;
  logic                            io_resp_yumi_i;
  logic                            cfg_w_v_o, cfg_r_v_o;
  logic [15:0]                     cfg_addr_o;
  logic [63:0]                     cfg_data_o;
  logic [63:0]                     cfg_data_i;
  logic                            err_o;
  bp_cce_mem_msg_s                 resp_s;

  int n_asserts = 0;
  int n_fail = 0;

  assign resp_s = io_resp_o;

  always #5 clk_i = ~clk_i;

  bp_me_cfg_io_responder #(.resp_els_p(2), .cfg_addr_width_p(16), .cfg_data_width_p(64)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .cfg_w_v_o(cfg_w_v_o), .cfg_r_v_o(cfg_r_v_o), .cfg_addr_o(cfg_addr_o),
    .cfg_data_o(cfg_data_o), .cfg_data_i(cfg_data_i), .err_o(err_o)
  );

  function automatic bp_cce_mem_msg_s mk(bp_cce_mem_cmd_type_e t, logic [39:0] a,
                                         logic [1:0] lce, logic [511:0] d);
    bp_cce_mem_msg_s m;
    m = '0;
    m.header.msg_type       = t;
    m.header.addr           = a;
    m.header.size           = 3'd3;
    m.header.payload.lce_id = lce;
    m.data                  = d;
    return m;
  endfunction

  task automatic test_reset;
    reset_n_i = 1'b0;
    #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", io_cmd_ready_o); end
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_v got=%b exp=0", io_resp_v_o); end
    n_asserts++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_o); end
    n_asserts++; if ({cfg_w_v_o, cfg_r_v_o} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got=%b exp=00", {cfg_w_v_o, cfg_r_v_o}); end
    @(negedge clk_i); @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i); #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL rel_ready_edge1 got=%b exp=0", io_cmd_ready_o); end
    n_asserts++; if (dut.state_r !== eRun) begin n_fail++; $display("FAIL rel_state got=%0d exp=%0d", dut.state_r, eRun); end
    @(negedge clk_i); #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rel_ready_edge2 got=%b exp=1", io_cmd_ready_o); end
  endtask

  task automatic test_uc_wr;
    @(negedge clk_i);
    io_cmd_i = mk(e_cce_mem_uc_wr, 40'h10, 2'd1, 512'hDEAD_BEEF);
    io_cmd_v_i = 1'b1;
    #1;
    n_asserts++; if (cfg_w_v_o !== 1'b1) begin n_fail++; $display("FAIL wr_strobe got=%b exp=1", cfg_w_v_o); end
    n_asserts++; if (cfg_r_v_o !== 1'b0) begin n_fail++; $display("FAIL wr_rstrobe got=%b exp=0", cfg_r_v_o); end
    n_asserts++; if (cfg_addr_o !== 16'h0010) begin n_fail++; $display("FAIL wr_addr got=%h exp=0010", cfg_addr_o); end
    n_asserts++; if (cfg_data_o !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_data got=%h exp=deadbeef", cfg_data_o); end
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL wr_no_bypass got=%b exp=0", io_resp_v_o); end
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    #1;
    n_asserts++; if (cfg_w_v_o !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_1cyc got=%b exp=0", cfg_w_v_o); end
    n_asserts++; if (io_resp_v_o !== 1'b1) begin n_fail++; $display("FAIL wr_resp_v got=%b exp=1", io_resp_v_o); end
    n_asserts++; if (resp_s.header.msg_type !== e_cce_mem_uc_wr) begin n_fail++; $display("FAIL wr_resp_type got=%0d exp=%0d", resp_s.header.msg_type, e_cce_mem_uc_wr); end
    n_asserts++; if (resp_s.header.payload.lce_id !== 2'd1) begin n_fail++; $display("FAIL wr_resp_lce got=%0d exp=1", resp_s.header.payload.lce_id); end
    n_asserts++; if (resp_s.header.addr !== 40'h10) begin n_fail++; $display("FAIL wr_resp_addr got=%h exp=10", resp_s.header.addr); end
    n_asserts++; if (resp_s.data !== '0) begin n_fail++; $display("FAIL wr_resp_data got=%h exp=0", resp_s.data); end
    io_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
    #1;
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL wr_drained got=%b exp=0", io_resp_v_o); end
  endtask

  task automatic test_uc_rd;
    @(negedge clk_i);
    cfg_data_i = 64'h1234;
    io_cmd_i = mk(e_cce_mem_uc_rd, 40'h20, 2'd2, 512'hFFFF);
    io_cmd_v_i = 1'b1;
    #1;
    n_asserts++; if (cfg_r_v_o !== 1'b1) begin n_fail++; $display("FAIL rd_strobe got=%b exp=1", cfg_r_v_o); end
    n_asserts++; if (cfg_w_v_o !== 1'b0) begin n_fail++; $display("FAIL rd_wstrobe got=%b exp=0", cfg_w_v_o); end
    n_asserts++; if (cfg_addr_o !== 16'h0020) begin n_fail++; $display("FAIL rd_addr got=%h exp=0020", cfg_addr_o); end
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    cfg_data_i = 64'h5555;
    io_resp_yumi_i = 1'b1;
    #1;
    n_asserts++; if (io_resp_v_o !== 1'b1) begin n_fail++; $display("FAIL rd_resp_v got=%b exp=1", io_resp_v_o); end
    n_asserts++; if (resp_s.data !== 512'h1234) begin n_fail++; $display("FAIL rd_resp_data got=%h exp=1234", resp_s.data); end
    n_asserts++; if (resp_s.header.msg_type !== e_cce_mem_uc_rd) begin n_fail++; $display("FAIL rd_resp_type got=%0d exp=%0d", resp_s.header.msg_type, e_cce_mem_uc_rd); end
    n_asserts++; if (resp_s.header.payload.lce_id !== 2'd2) begin n_fail++; $display("FAIL rd_resp_lce got=%0d exp=2", resp_s.header.payload.lce_id); end
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
    #1;
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL rd_drained got=%b exp=0", io_resp_v_o); end
  endtask

  task automatic test_backpressure;
    @(negedge clk_i);
    io_cmd_i = mk(e_cce_mem_uc_wr, 40'h31, 2'd0, 512'h1);
    io_cmd_v_i = 1'b1;
    #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a got=%b exp=1", io_cmd_ready_o); end
    @(negedge clk_i);
    io_cmd_i = mk(e_cce_mem_uc_wr, 40'h32, 2'd0, 512'h2);
    #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b got=%b exp=1", io_cmd_ready_o); end
    @(negedge clk_i);
    io_cmd_i = mk(e_cce_mem_uc_wr, 40'h33, 2'd0, 512'h3);
    #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got=%b exp=0", io_cmd_ready_o); end
    n_asserts++; if (cfg_w_v_o !== 1'b0) begin n_fail++; $display("FAIL bp_blocked_strobe got=%b exp=0", cfg_w_v_o); end
    n_asserts++; if (dut.state_r !== eFull) begin n_fail++; $display("FAIL bp_state_full got=%0d exp=%0d", dut.state_r, eFull); end
    n_asserts++; if (dut.count_r !== 2'd2) begin n_fail++; $display("FAIL bp_count got=%0d exp=2", dut.count_r); end
    @(negedge clk_i); #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold got=%b exp=0", io_cmd_ready_o); end
    n_asserts++; if (resp_s.header.addr !== 40'h31) begin n_fail++; $display("FAIL bp_order_1 got=%h exp=31", resp_s.header.addr); end
    io_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
    #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_reopen got=%b exp=1", io_cmd_ready_o); end
    n_asserts++; if (dut.state_r !== eRun) begin n_fail++; $display("FAIL bp_state_run got=%0d exp=%0d", dut.state_r, eRun); end
    n_asserts++; if (resp_s.header.addr !== 40'h32) begin n_fail++; $display("FAIL bp_order_2 got=%h exp=32", resp_s.header.addr); end
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_third_accepted got=%b exp=0", io_cmd_ready_o); end
    for (int k = 0; k < 2; k++) begin
      n_asserts++; if (io_resp_v_o !== 1'b1) begin n_fail++; $display("FAIL bp_drain_v k=%0d got=%b exp=1", k, io_resp_v_o); end
      n_asserts++; if (resp_s.header.addr !== 40'h32 + 40'(k)) begin n_fail++; $display("FAIL bp_drain_order k=%0d got=%h exp=%h", k, resp_s.header.addr, 40'h32 + 40'(k)); end
      io_resp_yumi_i = 1'b1;
      @(negedge clk_i); #1;
    end
    io_resp_yumi_i = 1'b0;
    #1;
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", io_resp_v_o); end
    n_asserts++; if (io_cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_empty got=%b exp=1", io_cmd_ready_o); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk_i);
    io_cmd_i = mk(e_cce_mem_uc_wr, 40'h100, 2'd3, 512'h0);
    io_cmd_v_i = 1'b1;
    #1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      io_cmd_i = mk(e_cce_mem_uc_wr, 40'h100 + 40'(i), 2'd3, 512'h0);
      io_resp_yumi_i = 1'b1;
      #1;
      n_asserts++; if (io_cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, io_cmd_ready_o); end
      n_asserts++; if (dut.count_r !== 2'd1) begin n_fail++; $display("FAIL b2b_count i=%0d got=%0d exp=1", i, dut.count_r); end
      n_asserts++; if (resp_s.header.addr !== 40'h100 + 40'(i - 1)) begin n_fail++; $display("FAIL b2b_order i=%0d got=%h exp=%h", i, resp_s.header.addr, 40'h100 + 40'(i - 1)); end
    end
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    #1;
    n_asserts++; if (resp_s.header.addr !== 40'h108) begin n_fail++; $display("FAIL b2b_last got=%h exp=108", resp_s.header.addr); end
    n_asserts++; if (dut.count_r !== 2'd1) begin n_fail++; $display("FAIL b2b_count_end got=%0d exp=1", dut.count_r); end
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
    #1;
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got=%b exp=0", io_resp_v_o); end
  endtask

  task automatic test_unsupported;
    @(negedge clk_i);
    io_cmd_i = mk(e_cce_mem_rd, 40'h40, 2'd1, 512'hABCD);
    io_cmd_v_i = 1'b1;
    #1;
    n_asserts++; if ({cfg_w_v_o, cfg_r_v_o} !== 2'b00) begin n_fail++; $display("FAIL unsup_strobes got=%b exp=00", {cfg_w_v_o, cfg_r_v_o}); end
    n_asserts++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL unsup_err_early got=%b exp=0", err_o); end
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    #1;
    n_asserts++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL unsup_err got=%b exp=1", err_o); end
    n_asserts++; if (io_resp_v_o !== 1'b1) begin n_fail++; $display("FAIL unsup_resp_v got=%b exp=1", io_resp_v_o); end
    n_asserts++; if (resp_s.data !== '0) begin n_fail++; $display("FAIL unsup_data got=%h exp=0", resp_s.data); end
    n_asserts++; if (resp_s.header.msg_type !== e_cce_mem_rd) begin n_fail++; $display("FAIL unsup_type got=%0d exp=%0d", resp_s.header.msg_type, e_cce_mem_rd); end
    io_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i); #1;
    n_asserts++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL unsup_err_sticky got=%b exp=1", err_o); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    io_cmd_i = mk(e_cce_mem_uc_wr, 40'h51, 2'd0, 512'h0);
    io_cmd_v_i = 1'b1;
    @(negedge clk_i);
    io_cmd_i = mk(e_cce_mem_uc_wr, 40'h52, 2'd0, 512'h0);
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    #1;
    n_asserts++; if (dut.count_r !== 2'd2) begin n_fail++; $display("FAIL mid_prefill got=%0d exp=2", dut.count_r); end
    #2;
    reset_n_i = 1'b0;
    #1;
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL mid_resp_v got=%b exp=0", io_resp_v_o); end
    n_asserts++; if (io_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", io_cmd_ready_o); end
    n_asserts++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%b exp=0", err_o); end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i); #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_rel_edge1 got=%b exp=0", io_cmd_ready_o); end
    @(negedge clk_i); #1;
    n_asserts++; if (io_cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_rel_edge2 got=%b exp=1", io_cmd_ready_o); end
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL mid_stale got=%b exp=0", io_resp_v_o); end
    io_cmd_i = mk(e_cce_mem_uc_wr, 40'h60, 2'd0, 512'h0);
    io_cmd_v_i = 1'b1;
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    #1;
    n_asserts++; if (resp_s.header.addr !== 40'h60) begin n_fail++; $display("FAIL mid_fresh got=%h exp=60", resp_s.header.addr); end
    io_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
    #1;
    n_asserts++; if (io_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL mid_empty got=%b exp=0", io_resp_v_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    io_cmd_i       = '0;
    io_cmd_v_i     = 1'b0;
    io_resp_yumi_i = 1'b0;
    cfg_data_i     = '0;
    test_reset();
    test_uc_wr();
    test_uc_rd();
    test_backpressure();
    test_back_to_back();
    test_unsupported();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
